// File: rtl/core_pkg.sv
// Shared definitions for the integer register file: default sizes, the clear/ready
// state encoding and a helper that extracts one port slice from a packed bus.
package core_pkg;

    localparam int XLEN_DEFAULT     = 32;
    localparam int NUM_REGS_DEFAULT = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // Slice 'port' of a packed bus whose slices are 'width' bits wide (width <= 16).
    function automatic logic [15:0] rf_port_slice(input logic [63:0] packed_vec,
                                                  input int port,
                                                  input int width);
        logic [63:0] mask_s;
        mask_s = (64'd1 << width) - 64'd1;
        return 16'((packed_vec >> (port * width)) & mask_s);
    endfunction

endpackage

// File: rtl/register_file_clear_ctrl.sv
// Post-reset clear sequencer: walks every register index once, driving clear_en and
// clear_addr to the storage array, then raises ready for the rest of operation.
module register_file_clear_ctrl
    import core_pkg::*;
#(
    parameter int  NUM_REGS = NUM_REGS_DEFAULT,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          clear_en,
    output logic [AW-1:0] clear_addr,
    output logic          ready
);

    rf_state_e     state_r;
    rf_state_e     state_nx_s;
    logic [AW-1:0] clr_idx_r;
    logic [AW-1:0] clr_idx_nx_s;
    logic          ready_r;

    // State, clear index and ready flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= RF_CLEAR;
            clr_idx_r <= {AW{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            clr_idx_r <= clr_idx_nx_s;
            ready_r   <= (state_nx_s == RF_READY);
        end
    end

    // Next-state logic: the last index is cleared on the same edge that enters READY.
    always_comb begin
        state_nx_s   = state_r;
        clr_idx_nx_s = clr_idx_r;
        case (state_r)
            RF_CLEAR: begin
                if (clr_idx_r == AW'(NUM_REGS - 1)) begin
                    state_nx_s   = RF_READY;
                    clr_idx_nx_s = {AW{1'b0}};
                end else begin
                    clr_idx_nx_s = clr_idx_r + AW'(1);
                end
            end
            RF_READY: begin
                state_nx_s = RF_READY;
            end
            default: begin
                state_nx_s   = RF_CLEAR;
                clr_idx_nx_s = {AW{1'b0}};
            end
        endcase
    end

    assign clear_en   = (state_r == RF_CLEAR);
    assign clear_addr = clr_idx_r;
    assign ready      = ready_r;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with post-reset clear and optional hardwired zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file_mp
    import core_pkg::*;
#(
    parameter int  XLEN     = XLEN_DEFAULT,
    parameter int  NUM_REGS = NUM_REGS_DEFAULT,
    parameter int  NUM_READ = 2,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_READ*AW-1:0]   rs,
    output logic [NUM_READ*XLEN-1:0] rs_data,
    input  logic [AW-1:0]            rd,
    input  logic [XLEN-1:0]          data,
    input  logic                     reg_write,
    output logic                     ready
);

    logic [XLEN-1:0] regs_r [NUM_REGS];
    logic            clear_en_s;
    logic [AW-1:0]   clear_addr_s;
    logic            ready_s;
    logic            wr_zero_s;
    logic            wr_en_s;

    register_file_clear_ctrl #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_ctrl (
        .clock      (clock),
        .reset      (reset),
        .clear_en   (clear_en_s),
        .clear_addr (clear_addr_s),
        .ready      (ready_s)
    );

    assign ready     = ready_s;
    assign wr_zero_s = (ZERO_REG != 0) && (rd == {AW{1'b0}});
    assign wr_en_s   = ready_s && reg_write && !wr_zero_s;

    // Storage: the clear engine owns the array until ready, writeback afterwards.
    always_ff @(posedge clock) begin
        if (clear_en_s) begin
            regs_r[clear_addr_s] <= {XLEN{1'b0}};
        end else if (wr_en_s) begin
            regs_r[rd] <= data;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : gen_rd_port
        logic [AW-1:0]   addr_s;
        logic            byp_s;
        logic [XLEN-1:0] rd_val_s;

        assign addr_s = AW'(rf_port_slice(64'(rs), k, AW));

`ifdef REGFILE_BYPASS_EN
        assign byp_s = wr_en_s && (rd == addr_s);
`else
        assign byp_s = 1'b0;
`endif

        // Read mux: blanked until ready, register 0 forced low when hardwired.
        always_comb begin
            rd_val_s = {XLEN{1'b0}};
            if (!ready_s) begin
                rd_val_s = {XLEN{1'b0}};
            end else if ((ZERO_REG != 0) && (addr_s == {AW{1'b0}})) begin
                rd_val_s = {XLEN{1'b0}};
            end else if (byp_s) begin
                rd_val_s = data;
            end else begin
                rd_val_s = regs_r[addr_s];
            end
        end

        assign rs_data[k*XLEN +: XLEN] = rd_val_s;
    end

endmodule
